// File: rtl/wb_checker.sv
// In-order writeback checker: queues expected retirements and compares them against the core's register-file writes.
// Optional macro WBCHK_ZERO_CHECK_EN stores exp_zero in the FIFO and adds the ALU Zero flag to the match condition.
module wb_checker #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             enable,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [RA_W-1:0]  exp_rd,
    input  logic [XLEN-1:0]  exp_data,
    input  logic             exp_zero,
    input  logic             exp_last,
    input  logic             obs_valid,
    input  logic [RA_W-1:0]  obs_rd,
    input  logic [XLEN-1:0]  obs_data,
    input  logic             obs_zero,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] chk_idx,
    output logic             done,
    output logic             error,
    output logic             underflow,
    output logic             overrun,
    output logic             mis_valid,
    output logic [CNT_W-1:0] mis_idx,
    output logic [RA_W-1:0]  mis_rd,
    output logic [XLEN-1:0]  mis_got,
    output logic [XLEN-1:0]  mis_exp
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_LW = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_r;

    logic [RA_W-1:0]   rd_mem_r   [DEPTH];
    logic [XLEN-1:0]   data_mem_r [DEPTH];
    logic              last_mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_LW-1:0] count_r;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;
    logic zero_ok_s;
    logic match_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign full_s    = (count_r == CNT_LW'(DEPTH));
    assign empty_s   = (count_r == CNT_LW'(0));
    assign exp_ready = !full_s;
    assign push_s    = exp_valid && !full_s;
    // Compare only sees the registered head; a same-cycle push never bypasses into it.
    assign pop_s     = (state_r == ST_RUN) && obs_valid && !empty_s;

`ifdef WBCHK_ZERO_CHECK_EN
    logic zero_mem_r [DEPTH];

    // Zero-flag storage alongside each queued entry.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            zero_mem_r[wr_ptr_r] <= exp_zero;
        end
    end

    assign zero_ok_s = (obs_zero == zero_mem_r[rd_ptr_r]);
`else
    logic unused_zero_s;
    assign unused_zero_s = exp_zero ^ obs_zero;
    assign zero_ok_s     = 1'b1;
`endif

    assign match_s = (obs_rd == rd_mem_r[rd_ptr_r]) && (obs_data == data_mem_r[rd_ptr_r]) && zero_ok_s;
    assign error   = (fail_cnt != CNT_W'(0)) || underflow || overrun;

    // Expectation payload storage; contents need no reset since count gates every read.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            rd_mem_r[wr_ptr_r]   <= exp_rd;
            data_mem_r[wr_ptr_r] <= exp_data;
            last_mem_r[wr_ptr_r] <= exp_last;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_LW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_LW'(1);
                2'b01:   count_r <= count_r - CNT_LW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Checker FSM with counters, sticky flags and first-mismatch capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            pass_cnt  <= CNT_W'(0);
            fail_cnt  <= CNT_W'(0);
            chk_idx   <= CNT_W'(0);
            done      <= 1'b0;
            underflow <= 1'b0;
            overrun   <= 1'b0;
            mis_valid <= 1'b0;
            mis_idx   <= CNT_W'(0);
            mis_rd    <= RA_W'(0);
            mis_got   <= XLEN'(0);
            mis_exp   <= XLEN'(0);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (obs_valid && !empty_s) begin
                        chk_idx <= sat_inc(chk_idx);
                        if (match_s) begin
                            pass_cnt <= sat_inc(pass_cnt);
                        end else begin
                            fail_cnt <= sat_inc(fail_cnt);
                            if (!mis_valid) begin
                                mis_valid <= 1'b1;
                                mis_idx   <= chk_idx;
                                mis_rd    <= obs_rd;
                                mis_got   <= obs_data;
                                mis_exp   <= data_mem_r[rd_ptr_r];
                            end
                        end
                        if (last_mem_r[rd_ptr_r]) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end
                    end else if (obs_valid) begin
                        underflow <= 1'b1;
                        fail_cnt  <= sat_inc(fail_cnt);
                    end
                end
                ST_DONE: begin
                    if (obs_valid) begin
                        overrun <= 1'b1;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_checker.sv
// Directed self-checking bench for wb_checker with hand-computed expectations per scenario.
module tb_wb_checker;

    logic        CLK = 1'b0;
    logic        RST;
    logic        enable;
    logic        exp_valid;
    logic        exp_ready;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic        exp_zero;
    logic        exp_last;
    logic        obs_valid;
    logic [4:0]  obs_rd;
    logic [31:0] obs_data;
    logic        obs_zero;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;
    logic [15:0] chk_idx;
    logic        done;
    logic        error;
    logic        underflow;
    logic        overrun;
    logic        mis_valid;
    logic [15:0] mis_idx;
    logic [4:0]  mis_rd;
    logic [31:0] mis_got;
    logic [31:0] mis_exp;

    int vecs = 0;
    int errs = 0;

    wb_checker #(.XLEN(32), .RA_W(5), .DEPTH(16), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .enable(enable),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_rd(exp_rd),
        .exp_data(exp_data), .exp_zero(exp_zero), .exp_last(exp_last),
        .obs_valid(obs_valid), .obs_rd(obs_rd), .obs_data(obs_data), .obs_zero(obs_zero),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .chk_idx(chk_idx), .done(done),
        .error(error), .underflow(underflow), .overrun(overrun), .mis_valid(mis_valid),
        .mis_idx(mis_idx), .mis_rd(mis_rd), .mis_got(mis_got), .mis_exp(mis_exp)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST = 1'b1; enable = 1'b0; exp_valid = 1'b0; exp_rd = 5'd0; exp_data = 32'd0;
        exp_zero = 1'b0; exp_last = 1'b0; obs_valid = 1'b0; obs_rd = 5'd0;
        obs_data = 32'd0; obs_zero = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] d, input logic z, input logic l);
        exp_valid = 1'b1; exp_rd = rd; exp_data = d; exp_zero = z; exp_last = l;
        tick();
        exp_valid = 1'b0; exp_last = 1'b0;
    endtask

    task automatic observe(input logic [4:0] rd, input logic [31:0] d, input logic z);
        obs_valid = 1'b1; obs_rd = rd; obs_data = d; obs_zero = z;
        tick();
        obs_valid = 1'b0;
    endtask

    task automatic start();
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        logic [143:0] all_s;
        all_s = {pass_cnt, fail_cnt, chk_idx, done, error, underflow, overrun, mis_valid,
                 mis_idx, mis_rd, mis_got, mis_exp};
        vecs++; if (all_s !== 144'd0) begin errs++; $display("FAIL %s_outputs got %h want 0", tag, all_s); end
        vecs++; if (exp_ready !== 1'b1) begin errs++; $display("FAIL %s_ready got %b want 1", tag, exp_ready); end
    endtask

    task automatic test_reset();
        apply_reset();
        check_reset_values("reset");
    endtask

    task automatic test_basic();
        apply_reset();
        push(5'd2, 32'd5, 1'b0, 1'b0);
        push(5'd3, 32'd12, 1'b0, 1'b0);
        push(5'd7, 32'd3, 1'b0, 1'b1);
        start();
        observe(5'd2, 32'd5, 1'b0);
        observe(5'd3, 32'd12, 1'b0);
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL basic_done_early got %b want 0", done); end
        observe(5'd7, 32'd3, 1'b0);
        vecs++; if (pass_cnt !== 16'd3) begin errs++; $display("FAIL basic_pass got %0d want 3", pass_cnt); end
        vecs++; if (fail_cnt !== 16'd0) begin errs++; $display("FAIL basic_fail got %0d want 0", fail_cnt); end
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL basic_done got %b want 1", done); end
        vecs++; if (error !== 1'b0) begin errs++; $display("FAIL basic_error got %b want 0", error); end
        vecs++; if (chk_idx !== 16'd3) begin errs++; $display("FAIL basic_idx got %0d want 3", chk_idx); end
        // Write after the program ended.
        observe(5'd9, 32'd1, 1'b0);
        vecs++; if (overrun !== 1'b1) begin errs++; $display("FAIL overrun_flag got %b want 1", overrun); end
        vecs++; if ({pass_cnt, fail_cnt, chk_idx} !== {16'd3, 16'd0, 16'd3}) begin
            errs++; $display("FAIL overrun_counters got %0d/%0d/%0d want 3/0/3", pass_cnt, fail_cnt, chk_idx); end
        vecs++; if (error !== 1'b1) begin errs++; $display("FAIL overrun_error got %b want 1", error); end
    endtask

    task automatic test_mismatch();
        apply_reset();
        push(5'd4, 32'd7, 1'b0, 1'b0);
        push(5'd6, 32'd1, 1'b0, 1'b0);
        push(5'd8, 32'd2, 1'b0, 1'b1);
        start();
        observe(5'd4, 32'd6, 1'b0);
        vecs++; if (fail_cnt !== 16'd1) begin errs++; $display("FAIL mis_fail got %0d want 1", fail_cnt); end
        vecs++; if ({mis_valid, mis_idx, mis_rd, mis_got, mis_exp} !== {1'b1, 16'd0, 5'd4, 32'd6, 32'd7}) begin
            errs++; $display("FAIL mis_record got v%b i%0d rd%0d g%0d e%0d want v1 i0 rd4 g6 e7",
                             mis_valid, mis_idx, mis_rd, mis_got, mis_exp); end
        observe(5'd6, 32'd1, 1'b0);
        vecs++; if (pass_cnt !== 16'd1) begin errs++; $display("FAIL mis_pass got %0d want 1", pass_cnt); end
        observe(5'd9, 32'd2, 1'b0);
        vecs++; if (fail_cnt !== 16'd2) begin errs++; $display("FAIL mis_fail2 got %0d want 2", fail_cnt); end
        vecs++; if ({mis_idx, mis_rd, mis_got, mis_exp} !== {16'd0, 5'd4, 32'd6, 32'd7}) begin
            errs++; $display("FAIL mis_sticky got i%0d rd%0d g%0d e%0d want i0 rd4 g6 e7",
                             mis_idx, mis_rd, mis_got, mis_exp); end
        vecs++; if ({done, chk_idx, error} !== {1'b1, 16'd3, 1'b1}) begin
            errs++; $display("FAIL mis_end got d%b i%0d e%b want d1 i3 e1", done, chk_idx, error); end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            push(5'(i + 1), 32'(i * 3), 1'b0, 1'b0);
        end
        vecs++; if (exp_ready !== 1'b0) begin errs++; $display("FAIL full_ready got %b want 0", exp_ready); end
        exp_valid = 1'b1; exp_rd = 5'd20; exp_data = 32'd99; exp_last = 1'b0;
        start();
        vecs++; if (exp_ready !== 1'b0) begin errs++; $display("FAIL full_hold got %b want 0", exp_ready); end
        // Pop with the push still offered: space frees only after this edge.
        observe(5'd1, 32'd0, 1'b0);
        exp_valid = 1'b1;
        vecs++; if (exp_ready !== 1'b1) begin errs++; $display("FAIL full_no_same_cycle got %b want 1", exp_ready); end
        vecs++; if (pass_cnt !== 16'd1) begin errs++; $display("FAIL full_pop_pass got %0d want 1", pass_cnt); end
        tick();
        exp_valid = 1'b0;
        vecs++; if (exp_ready !== 1'b0) begin errs++; $display("FAIL full_next_cycle got %b want 0", exp_ready); end
    endtask

    task automatic test_underflow();
        apply_reset();
        start();
        // Same-cycle push into the empty FIFO must not satisfy the compare.
        exp_valid = 1'b1; exp_rd = 5'd11; exp_data = 32'd44; exp_last = 1'b0;
        observe(5'd11, 32'd44, 1'b0);
        exp_valid = 1'b0;
        vecs++; if ({underflow, fail_cnt, chk_idx, error} !== {1'b1, 16'd1, 16'd0, 1'b1}) begin
            errs++; $display("FAIL underflow got u%b f%0d i%0d e%b want u1 f1 i0 e1", underflow, fail_cnt, chk_idx, error); end
        observe(5'd11, 32'd44, 1'b0);
        vecs++; if ({pass_cnt, chk_idx} !== {16'd1, 16'd1}) begin
            errs++; $display("FAIL underflow_late_entry got p%0d i%0d want p1 i1", pass_cnt, chk_idx); end
    endtask

    task automatic test_zero();
        logic [15:0] want_pass;
        logic [15:0] want_fail;
`ifdef WBCHK_ZERO_CHECK_EN
        want_pass = 16'd0; want_fail = 16'd1;
`else
        want_pass = 16'd1; want_fail = 16'd0;
`endif
        apply_reset();
        push(5'd5, 32'd0, 1'b1, 1'b1);
        start();
        observe(5'd5, 32'd0, 1'b0);
        vecs++; if ({pass_cnt, fail_cnt} !== {want_pass, want_fail}) begin
            errs++; $display("FAIL zero_check got p%0d f%0d want p%0d f%0d", pass_cnt, fail_cnt, want_pass, want_fail); end
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL zero_done got %b want 1", done); end
    endtask

    task automatic test_reset_midrun();
        apply_reset();
        push(5'd1, 32'd10, 1'b0, 1'b0);
        push(5'd2, 32'd20, 1'b0, 1'b0);
        push(5'd3, 32'd30, 1'b0, 1'b1);
        start();
        observe(5'd1, 32'd10, 1'b0);
        observe(5'd2, 32'd20, 1'b0);
        vecs++; if (pass_cnt !== 16'd2) begin errs++; $display("FAIL midrun_pass got %0d want 2", pass_cnt); end
        RST = 1'b1; exp_valid = 1'b1; obs_valid = 1'b1; obs_rd = 5'd3; obs_data = 32'd30;
        tick();
        RST = 1'b0; exp_valid = 1'b0; obs_valid = 1'b0;
        check_reset_values("midrun");
        start();
        observe(5'd3, 32'd30, 1'b0);
        vecs++; if ({underflow, fail_cnt, pass_cnt} !== {1'b1, 16'd1, 16'd0}) begin
            errs++; $display("FAIL midrun_flushed got u%b f%0d p%0d want u1 f1 p0", underflow, fail_cnt, pass_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_full();
        test_underflow();
        test_zero();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
